// File: rtl/tlb_inv_sweep_if.sv
// Invalidate-request, entry-read and entry-clear signals between the
// INVTLB sweep engine and the pipeline/TLB entry array.
interface tlb_inv_sweep_if #(
  parameter int TLBNUM = 32
);
  localparam int IDXW = $clog2(TLBNUM);

  logic            inv_en;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [18:0]     inv_vpn;
  logic [IDXW-1:0] rd_idx;
  logic            rd_e;
  logic            rd_g;
  logic [9:0]      rd_asid;
  logic [18:0]     rd_vppn;
  logic [5:0]      rd_ps;
  logic            clr_en;
  logic [IDXW-1:0] clr_idx;
  logic            busy;
  logic            done;
  logic            illegal_op;

  // master: the sweep engine, which drives the entry index and clears
  modport master (
    input  inv_en, inv_op, inv_asid, inv_vpn,
    input  rd_e, rd_g, rd_asid, rd_vppn, rd_ps,
    output rd_idx, clr_en, clr_idx, busy, done, illegal_op
  );

  // slave: the pipeline and entry array around the engine
  modport slave (
    output inv_en, inv_op, inv_asid, inv_vpn,
    output rd_e, rd_g, rd_asid, rd_vppn, rd_ps,
    input  rd_idx, clr_en, clr_idx, busy, done, illegal_op
  );
endinterface

// File: rtl/tlb_inv_sweep.sv
// Sequential INVTLB engine: walks every TLB entry once per request and
// clears the exist bit of entries matching the latched op/asid/vpn.
module tlb_inv_sweep #(
  parameter int TLBNUM = 32
) (
  input  logic            clk,
  input  logic            rst,
  tlb_inv_sweep_if.master bus
);
  localparam int IDXW = $clog2(TLBNUM);

  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [2:0]      op_q;
  logic [9:0]      asid_q;
  logic [18:0]     vpn_q;
  logic            busy_q;
  logic            done_q;
  logic            illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      op_q      <= '0;
      asid_q    <= '0;
      vpn_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.inv_en) begin
            if (bus.inv_op <= 5'd6) begin
              op_q   <= bus.inv_op[2:0];
              asid_q <= bus.inv_asid;
              vpn_q  <= bus.inv_vpn;
              idx    <= '0;
              state  <= SWEEP;
              busy_q <= 1'b1;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        SWEEP: begin
          // last entry wraps the counter back to 0 on the way to FINISH
          idx <= idx + 1'b1;
          if (idx == IDXW'(TLBNUM - 1)) begin
            state  <= FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic sweeping;
  logic asid_eq;
  logic va_eq;
  logic hit;

  assign sweeping = (state == SWEEP);
  assign asid_eq  = (bus.rd_asid == asid_q);
  // 4MB pages (ps=21) only carry VPPN bits [18:9]
  assign va_eq    = (bus.rd_ps == 6'd21) ? (bus.rd_vppn[18:9] == vpn_q[18:9])
                                         : (bus.rd_vppn == vpn_q);

  always_comb begin
    hit = 1'b0;
    case (op_q)
      3'd0, 3'd1: hit = 1'b1;
      3'd2:       hit = bus.rd_g;
      3'd3:       hit = !bus.rd_g;
      3'd4:       hit = !bus.rd_g && asid_eq;
      3'd5:       hit = !bus.rd_g && asid_eq && va_eq;
      3'd6:       hit = (bus.rd_g || asid_eq) && va_eq;
      default:    hit = 1'b0;
    endcase
  end

  assign bus.rd_idx     = sweeping ? idx : '0;
  assign bus.clr_idx    = bus.rd_idx;
  assign bus.clr_en     = sweeping && bus.rd_e && hit;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_tlb_inv_sweep.sv
// Directed bench for tlb_inv_sweep: a 32-entry array model plus a vector
// table for the match rules and hand sequences for timing corners.
module tb_tlb_inv_sweep;
  localparam int TLBNUM = 32;
  localparam int IDXW   = $clog2(TLBNUM);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_inv_sweep_if #(.TLBNUM(TLBNUM)) bus();
  tlb_inv_sweep #(.TLBNUM(TLBNUM)) dut (.clk(clk), .rst(rst), .bus(bus));

  // entry array model: static fields set by the test, clears recorded per edge
  logic [TLBNUM-1:0] e_set;
  logic [TLBNUM-1:0] g_arr;
  logic [9:0]        asid_arr [TLBNUM];
  logic [18:0]       vppn_arr [TLBNUM];
  logic [5:0]        ps_arr   [TLBNUM];
  logic [TLBNUM-1:0] cleared;
  logic              tb_wipe = 1'b0;

  always @(posedge clk) begin
    if (tb_wipe) cleared <= '0;
    else if (bus.clr_en) cleared[bus.clr_idx] <= 1'b1;
  end

  assign bus.rd_e    = e_set[bus.rd_idx] & ~cleared[bus.rd_idx];
  assign bus.rd_g    = g_arr[bus.rd_idx];
  assign bus.rd_asid = asid_arr[bus.rd_idx];
  assign bus.rd_vppn = vppn_arr[bus.rd_idx];
  assign bus.rd_ps   = ps_arr[bus.rd_idx];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wipe();
    e_set = '0;
    g_arr = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      asid_arr[i] = '0;
      vppn_arr[i] = '0;
      ps_arr[i]   = 6'd12;
    end
    tb_wipe = 1'b1;
    @(posedge clk); #1;
    tb_wipe = 1'b0;
  endtask

  // drive a request for one edge; returns #1 into the following cycle
  task automatic launch(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vpn);
    bus.inv_en   = 1'b1;
    bus.inv_op   = op;
    bus.inv_asid = asid;
    bus.inv_vpn  = vpn;
    @(posedge clk); #1;
    bus.inv_en   = 1'b0;
  endtask

  // c0 = sweep cycle index of the current cycle (0 = first sweep cycle)
  task automatic monitor(input int c0, output int nclr, output int nbusy,
                         output int done_c, output int seq_err);
    nclr = 0; nbusy = 0; done_c = -1; seq_err = 0;
    for (int c = c0; c < TLBNUM + 8; c++) begin
      if (bus.busy) begin
        nbusy++;
        if (int'(bus.rd_idx) != c || bus.clr_idx != bus.rd_idx) seq_err++;
      end
      if (bus.clr_en) begin
        nclr++;
        if (!bus.busy) seq_err++;
      end
      if (bus.done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [18:0] vpn;
    logic        e;
    logic        g;
    logic [9:0]  easid;
    logic [18:0] evppn;
    logic [5:0]  eps;
    logic        exp;
  } vec_t;

  vec_t vecs [19];

  initial begin
    int nclr, nbusy, done_c, seq_err, k;

    vecs[0]  = '{5'd0, 10'h000, 19'h00000, 1'b1, 1'b1, 10'h000, 19'h00000, 6'd12, 1'b1};
    vecs[1]  = '{5'd1, 10'h000, 19'h00000, 1'b1, 1'b0, 10'h000, 19'h00000, 6'd12, 1'b1};
    vecs[2]  = '{5'd2, 10'h000, 19'h00000, 1'b1, 1'b1, 10'h000, 19'h00000, 6'd12, 1'b1};
    vecs[3]  = '{5'd2, 10'h000, 19'h00000, 1'b1, 1'b0, 10'h000, 19'h00000, 6'd12, 1'b0};
    vecs[4]  = '{5'd3, 10'h000, 19'h00000, 1'b1, 1'b0, 10'h000, 19'h00000, 6'd12, 1'b1};
    vecs[5]  = '{5'd3, 10'h000, 19'h00000, 1'b1, 1'b1, 10'h000, 19'h00000, 6'd12, 1'b0};
    vecs[6]  = '{5'd4, 10'h005, 19'h00000, 1'b1, 1'b0, 10'h005, 19'h00000, 6'd12, 1'b1};
    vecs[7]  = '{5'd4, 10'h005, 19'h00000, 1'b1, 1'b0, 10'h006, 19'h00000, 6'd12, 1'b0};
    vecs[8]  = '{5'd4, 10'h005, 19'h00000, 1'b1, 1'b1, 10'h005, 19'h00000, 6'd12, 1'b0};
    vecs[9]  = '{5'd5, 10'h005, 19'h12345, 1'b1, 1'b0, 10'h005, 19'h12345, 6'd12, 1'b1};
    vecs[10] = '{5'd5, 10'h005, 19'h12345, 1'b1, 1'b0, 10'h005, 19'h12344, 6'd12, 1'b0};
    vecs[11] = '{5'd5, 10'h005, 19'h12345, 1'b1, 1'b1, 10'h005, 19'h12345, 6'd12, 1'b0};
    vecs[12] = '{5'd6, 10'h005, 19'h12345, 1'b1, 1'b1, 10'h009, 19'h12345, 6'd12, 1'b1};
    vecs[13] = '{5'd6, 10'h005, 19'h12345, 1'b1, 1'b0, 10'h009, 19'h12345, 6'd12, 1'b0};
    vecs[14] = '{5'd6, 10'h005, 19'h12345, 1'b1, 1'b0, 10'h005, 19'h123FF, 6'd21, 1'b1};
    vecs[15] = '{5'd6, 10'h005, 19'h12345, 1'b1, 1'b0, 10'h005, 19'h12344, 6'd12, 1'b0};
    vecs[16] = '{5'd6, 10'h005, 19'h12345, 1'b1, 1'b1, 10'h000, 19'h12145, 6'd21, 1'b0};
    vecs[17] = '{5'd0, 10'h000, 19'h00000, 1'b0, 1'b1, 10'h000, 19'h00000, 6'd12, 1'b0};
    vecs[18] = '{5'd5, 10'h005, 19'h12345, 1'b1, 1'b0, 10'h005, 19'h00345, 6'd21, 1'b0};

    bus.inv_en = 1'b0; bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vpn = '0;
    e_set = '0; g_arr = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      asid_arr[i] = '0; vppn_arr[i] = '0; ps_arr[i] = 6'd12;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_illegal", 32'(bus.illegal_op), 0);
    chk("rst_clr_en", 32'(bus.clr_en), 0);
    chk("rst_rd_idx", 32'(bus.rd_idx), 0);
    chk("rst_clr_idx", 32'(bus.clr_idx), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // op 0 over a fully populated array
    wipe();
    e_set = '1;
    launch(5'd0, 10'h0, 19'h0);
    monitor(0, nclr, nbusy, done_c, seq_err);
    chk("op0_nclr", 32'(nclr), 32);
    chk("op0_busy_cycles", 32'(nbusy), 32);
    chk("op0_done_cycle", 32'(done_c), 32);
    chk("op0_idx_seq", 32'(seq_err), 0);
    chk("op0_cleared", cleared, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("op0_done_pulse", 32'(bus.done), 0);
    chk("op0_busy_after", 32'(bus.busy), 0);

    // match rules, one live entry per vector
    for (int i = 0; i < 19; i++) begin
      wipe();
      k = (i * 7 + 31) % TLBNUM;
      e_set[k]    = vecs[i].e;
      g_arr[k]    = vecs[i].g;
      asid_arr[k] = vecs[i].easid;
      vppn_arr[k] = vecs[i].evppn;
      ps_arr[k]   = vecs[i].eps;
      launch(vecs[i].op, vecs[i].asid, vecs[i].vpn);
      monitor(0, nclr, nbusy, done_c, seq_err);
      chk($sformatf("vec%0d_nclr", i), 32'(nclr), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_entry", i), 32'(cleared[k]), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_done", i), 32'(done_c), 32);
      @(posedge clk); #1;
    end

    // op 4, asid 5
    wipe();
    e_set[3] = 1'b1; asid_arr[3] = 10'h005;
    e_set[7] = 1'b1; asid_arr[7] = 10'h005; g_arr[7] = 1'b1;
    e_set[9] = 1'b1; asid_arr[9] = 10'h006;
    launch(5'd4, 10'h005, 19'h0);
    monitor(0, nclr, nbusy, done_c, seq_err);
    chk("op4_cleared", cleared, 32'h0000_0008);
    @(posedge clk); #1;

    // op 6, vpn 0x12345 with a 4MB entry
    wipe();
    e_set[2] = 1'b1; g_arr[2] = 1'b1; asid_arr[2] = 10'h001; vppn_arr[2] = 19'h12345;
    e_set[4] = 1'b1; asid_arr[4] = 10'h003; vppn_arr[4] = 19'h12200; ps_arr[4] = 6'd21;
    e_set[5] = 1'b1; asid_arr[5] = 10'h003; vppn_arr[5] = 19'h12344;
    launch(5'd6, 10'h003, 19'h12345);
    monitor(0, nclr, nbusy, done_c, seq_err);
    chk("op6_cleared", cleared, 32'h0000_0014);
    @(posedge clk); #1;

    // reserved op, then a legal op in the very next cycle
    wipe();
    e_set = '1;
    launch(5'd7, 10'h0, 19'h0);
    chk("op7_illegal", 32'(bus.illegal_op), 1);
    chk("op7_busy", 32'(bus.busy), 0);
    chk("op7_clr_en", 32'(bus.clr_en), 0);
    launch(5'd0, 10'h0, 19'h0);
    chk("op7_illegal_pulse", 32'(bus.illegal_op), 0);
    chk("op7_next_accepted", 32'(bus.busy), 1);
    monitor(0, nclr, nbusy, done_c, seq_err);
    chk("op7_next_nclr", 32'(nclr), 32);
    @(posedge clk); #1;

    // second request during a sweep is dropped
    wipe();
    e_set = '1;
    g_arr = 32'h5555_5555;
    launch(5'd3, 10'h0, 19'h0);
    bus.inv_en = 1'b1; bus.inv_op = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    bus.inv_en = 1'b0;
    monitor(3, nclr, nbusy, done_c, seq_err);
    chk("busy_cleared", cleared, 32'hAAAA_AAAA);
    chk("busy_done_cycle", 32'(done_c), 32);
    nclr = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) nclr++;
    end
    chk("busy_no_requeue", 32'(nclr), 0);

    // reset mid-sweep at idx 10
    wipe();
    e_set = '1;
    launch(5'd0, 10'h0, 19'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_idx_before", 32'(bus.rd_idx), 10);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_clr_en", 32'(bus.clr_en), 0);
    chk("rstmid_rd_idx", 32'(bus.rd_idx), 0);
    @(posedge clk); #1;
    chk("rstmid_cleared", cleared, 32'h0000_03FF);
    chk("rstmid_done", 32'(bus.done), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    launch(5'd0, 10'h0, 19'h0);
    monitor(0, nclr, nbusy, done_c, seq_err);
    chk("rstmid_resweep_seq", 32'(seq_err), 0);
    chk("rstmid_resweep_nclr", 32'(nclr), 22);
    chk("rstmid_resweep_done", 32'(done_c), 32);
    chk("rstmid_resweep_all", cleared, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
